// File: rtl/dzcpu_useq_pkg.sv
// Shared z80 micro-sequencer definitions: states, flow codes and fixed flow indices.
package dzcpu_useq_pkg;

    typedef enum logic [2:0] {
        StFetch      = 3'd0,
        StDispatch   = 3'd1,
        StExec       = 3'd2,
        StCbFetch    = 3'd3,
        StCbDispatch = 3'd4
    } useq_state_e;

    // Flow field carried in iUop[12:9]; codes 10-15 are treated as FlowOp.
    localparam logic [3:0] FlowOp          = 4'd0;
    localparam logic [3:0] FlowInc         = 4'd1;
    localparam logic [3:0] FlowEof         = 4'd2;
    localparam logic [3:0] FlowIncEof      = 4'd3;
    localparam logic [3:0] FlowEofFu       = 4'd4;
    localparam logic [3:0] FlowIncEofFu    = 4'd5;
    localparam logic [3:0] FlowUpdateFlags = 4'd6;
    localparam logic [3:0] FlowIncEofZ     = 4'd7;
    localparam logic [3:0] FlowIncEofNz    = 4'd8;
    localparam logic [3:0] FlowNop         = 4'd9;

    localparam logic [4:0] OpJcb      = 5'h1F;
    localparam logic [7:0] IntFlowIdx = 8'd238;

endpackage

// File: rtl/dzcpu_useq_flowdec.sv
// Combinational decode of the micro-op flow field and op code into sequencer controls.
module dzcpu_useq_flowdec
    import dzcpu_useq_pkg::*;
(
    input  logic [3:0] i_flow,
    input  logic [4:0] i_op,
    input  logic       i_flag_z,
    output logic       o_inc,
    output logic       o_update_flags,
    output logic       o_eof_taken,
    output logic       o_jcb
);

    always_comb begin
        o_inc          = 1'b0;
        o_update_flags = 1'b0;
        o_eof_taken    = 1'b0;
        case (i_flow)
            FlowInc: o_inc = 1'b1;
            FlowEof: o_eof_taken = 1'b1;
            FlowIncEof: begin
                o_inc       = 1'b1;
                o_eof_taken = 1'b1;
            end
            FlowEofFu: begin
                o_update_flags = 1'b1;
                o_eof_taken    = 1'b1;
            end
            FlowIncEofFu: begin
                o_inc          = 1'b1;
                o_update_flags = 1'b1;
                o_eof_taken    = 1'b1;
            end
            FlowUpdateFlags: o_update_flags = 1'b1;
            FlowIncEofZ: begin
                o_inc       = 1'b1;
                o_eof_taken = i_flag_z;
            end
            FlowIncEofNz: begin
                o_inc       = 1'b1;
                o_eof_taken = ~i_flag_z;
            end
            default: ;
        endcase
    end

    assign o_jcb = (i_op == OpJcb);

endmodule

// File: rtl/dzcpu_useq.sv
// Micro-sequencer: fetches opcodes, dispatches through the flow LUTs and steps the ucode ROM.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset_n,
    input  logic [7:0]  iMop,
    input  logic [7:0]  iFlowIdx,
    input  logic [7:0]  iCbFlowIdx,
    input  logic [12:0] iUop,
    input  logic        iFlagZ,
    input  logic        iStall,
    input  logic        iIntReq,
    output logic [7:0]  oMop,
    output logic [7:0]  oUopAddr,
    output logic        oUopValid,
    output logic [8:0]  oUopBody,
    output logic        oPcInc,
    output logic        oUpdateFlags,
    output logic        oEof,
    output logic        oIntAck
);

    useq_state_e r_state, w_state_d;
    logic [7:0]  r_upc, w_upc_d;
    logic [7:0]  r_mop, w_mop_d;
    logic        w_inc, w_update_flags, w_eof_taken, w_jcb;

    dzcpu_useq_flowdec u_flowdec (
        .i_flow         (iUop[12:9]),
        .i_op           (iUop[8:4]),
        .i_flag_z       (iFlagZ),
        .o_inc          (w_inc),
        .o_update_flags (w_update_flags),
        .o_eof_taken    (w_eof_taken),
        .o_jcb          (w_jcb)
    );

    always_comb begin
        w_state_d    = r_state;
        w_upc_d      = r_upc;
        w_mop_d      = r_mop;
        oUopValid    = 1'b0;
        oPcInc       = 1'b0;
        oUpdateFlags = 1'b0;
        oEof         = 1'b0;
        oIntAck      = 1'b0;
        if (!iStall) begin
            case (r_state)
                StFetch: begin
                    w_mop_d   = iMop;
                    w_state_d = StDispatch;
                end
                StDispatch: begin
                    w_upc_d   = iFlowIdx;
                    w_state_d = StExec;
                end
                StCbFetch: begin
                    w_mop_d   = iMop;
                    w_state_d = StCbDispatch;
                end
                StCbDispatch: begin
                    w_upc_d   = iCbFlowIdx;
                    w_state_d = StExec;
                end
                StExec: begin
                    oUopValid    = 1'b1;
                    oPcInc       = w_inc;
                    oUpdateFlags = w_update_flags;
                    // JCB overrides any end-of-flow meaning of the flow field.
                    if (w_jcb) begin
                        w_state_d = StCbFetch;
                    end else if (w_eof_taken) begin
                        oEof = 1'b1;
                        if (iIntReq) begin
                            oIntAck = 1'b1;
                            w_upc_d = IntFlowIdx;
                        end else begin
                            w_state_d = StFetch;
                        end
                    end else begin
                        w_upc_d = r_upc + 8'd1;
                    end
                end
                default: w_state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= StFetch;
            r_upc   <= 8'd0;
            r_mop   <= 8'd0;
        end else begin
            r_state <= w_state_d;
            r_upc   <= w_upc_d;
            r_mop   <= w_mop_d;
        end
    end

    assign oMop     = r_mop;
    assign oUopAddr = r_upc;
    assign oUopBody = iUop[8:0];

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq: bench-side ROM/LUT models and a per-cycle expectation table.
module tb_dzcpu_useq;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic [7:0]  iMop;
    logic [7:0]  iFlowIdx;
    logic [7:0]  iCbFlowIdx;
    logic [12:0] iUop;
    logic        iFlagZ;
    logic        iStall;
    logic        iIntReq;
    logic [7:0]  oMop;
    logic [7:0]  oUopAddr;
    logic        oUopValid;
    logic [8:0]  oUopBody;
    logic        oPcInc;
    logic        oUpdateFlags;
    logic        oEof;
    logic        oIntAck;

    // Strobe pattern bits: {valid, pc_inc, update_flags, eof, int_ack}
    localparam logic [4:0] V  = 5'b10000;
    localparam logic [4:0] PI = 5'b01000;
    localparam logic [4:0] UF = 5'b00100;
    localparam logic [4:0] EF = 5'b00010;
    localparam logic [4:0] IA = 5'b00001;

    typedef struct {
        logic [7:0] mop;
        logic       z;
        logic       stall;
        logic       irq;
        logic [7:0] addr;
        logic [4:0] st;
        logic [7:0] omop;
    } vec_t;

    logic [12:0] rom      [256];
    logic [7:0]  flow_lut [256];
    logic [7:0]  cb_lut   [256];
    vec_t        vecs[$];
    int          n_pass = 0;
    int          n_total = 0;

    dzcpu_useq u_dut (
        .iClock       (iClock),
        .iReset_n     (iReset_n),
        .iMop         (iMop),
        .iFlowIdx     (iFlowIdx),
        .iCbFlowIdx   (iCbFlowIdx),
        .iUop         (iUop),
        .iFlagZ       (iFlagZ),
        .iStall       (iStall),
        .iIntReq      (iIntReq),
        .oMop         (oMop),
        .oUopAddr     (oUopAddr),
        .oUopValid    (oUopValid),
        .oUopBody     (oUopBody),
        .oPcInc       (oPcInc),
        .oUpdateFlags (oUpdateFlags),
        .oEof         (oEof),
        .oIntAck      (oIntAck)
    );

    always #5 iClock = ~iClock;

    assign iUop       = rom[oUopAddr];
    assign iFlowIdx   = flow_lut[oMop];
    assign iCbFlowIdx = cb_lut[oMop];

    function automatic logic [12:0] uop(input logic [3:0] flow, input logic [4:0] op,
                                        input logic [3:0] tag);
        return {flow, op, tag};
    endfunction

    task automatic check(input string name, input logic [7:0] addr, input logic [4:0] st,
                         input logic [7:0] omop);
        logic [29:0] got, exp;
        got = {oUopAddr, oUopValid, oPcInc, oUpdateFlags, oEof, oIntAck, oMop, oUopBody};
        exp = {addr, st, omop, rom[addr][8:0]};
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got addr/strobes/mop/body=%h, expected %h", name, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected normal completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]      = uop(4'd0, 5'd0, 4'hA);
            flow_lut[i] = 8'd0;
            cb_lut[i]   = 8'd0;
        end
        rom[0]   = uop(4'd2, 5'd0, 4'h1);
        rom[13]  = uop(4'd1, 5'd0, 4'h3);
        rom[14]  = uop(4'd0, 5'd2, 4'h4);
        rom[15]  = uop(4'd1, 5'h1F, 4'h5);
        rom[16]  = uop(4'd4, 5'd3, 4'h6);
        rom[17]  = uop(4'd0, 5'd4, 4'h7);
        rom[18]  = uop(4'd1, 5'd5, 4'h8);
        rom[19]  = uop(4'd7, 5'd6, 4'h9);
        rom[20]  = uop(4'd12, 5'd7, 4'hB);
        rom[21]  = uop(4'd9, 5'd8, 4'hC);
        rom[22]  = uop(4'd2, 5'd9, 4'hD);
        rom[48]  = uop(4'd0, 5'd10, 4'h0);
        rom[49]  = uop(4'd0, 5'd11, 4'h1);
        rom[50]  = uop(4'd1, 5'd12, 4'h2);
        rom[51]  = uop(4'd2, 5'd13, 4'h3);
        rom[162] = uop(4'd3, 5'd14, 4'h4);
        rom[238] = uop(4'd2, 5'd15, 4'h5);
        rom[255] = uop(4'd0, 5'd16, 4'h6);
        flow_lut[8'h00] = 8'd162;
        flow_lut[8'h20] = 8'd17;
        flow_lut[8'hCB] = 8'd13;
        flow_lut[8'h01] = 8'd48;
        flow_lut[8'h02] = 8'd255;
        cb_lut[8'h7C]   = 8'd16;

        // {mop, z, stall, irq, exp addr, exp strobes, exp oMop}
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b0, 8'd0,   5'd0,      8'h00}); // NOP fetch
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd0,   5'd0,      8'h00});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd162, V|PI|EF,   8'h00});
        vecs.push_back('{8'h20, 1'b0, 1'b0, 1'b0, 8'd162, 5'd0,      8'h00}); // JRNZ, Z=1
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd162, 5'd0,      8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd17,  V,         8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd18,  V|PI,      8'h20});
        vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 8'd19,  V|PI|EF,   8'h20});
        vecs.push_back('{8'h20, 1'b0, 1'b0, 1'b0, 8'd19,  5'd0,      8'h20}); // JRNZ, Z=0
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd19,  5'd0,      8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd17,  V,         8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd18,  V|PI,      8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd19,  V|PI,      8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd20,  V,         8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd21,  V,         8'h20});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd22,  V|EF,      8'h20});
        vecs.push_back('{8'hCB, 1'b0, 1'b0, 1'b0, 8'd22,  5'd0,      8'h20}); // CB prefix
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd22,  5'd0,      8'hCB});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd13,  V|PI,      8'hCB});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd14,  V,         8'hCB});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd15,  V|PI,      8'hCB});
        vecs.push_back('{8'h7C, 1'b0, 1'b0, 1'b0, 8'd15,  5'd0,      8'hCB});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd15,  5'd0,      8'h7C});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd16,  V|UF|EF,   8'h7C});
        vecs.push_back('{8'h01, 1'b0, 1'b0, 1'b0, 8'd16,  5'd0,      8'h7C}); // stall flow
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd16,  5'd0,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd48,  V,         8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd49,  V,         8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'd50,  5'd0,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b0, 8'd50,  5'd0,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b0, 8'd50,  5'd0,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd50,  V|PI,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b1, 8'd51,  V|EF|IA,   8'h01}); // interrupt
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd238, V|EF,      8'h01});
        vecs.push_back('{8'h02, 1'b0, 1'b1, 1'b0, 8'd238, 5'd0,      8'h01}); // stalled fetch
        vecs.push_back('{8'h02, 1'b0, 1'b0, 1'b0, 8'd238, 5'd0,      8'h01});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd238, 5'd0,      8'h02}); // uPC wrap
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd255, V,         8'h02});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 8'd0,   V|EF,      8'h02});
        vecs.push_back('{8'h01, 1'b0, 1'b0, 1'b0, 8'd0,   5'd0,      8'h02});

        iReset_n = 1'b0;
        iMop     = 8'hFF;
        iFlagZ   = 1'b0;
        iStall   = 1'b0;
        iIntReq  = 1'b0;
        #3;
        check("reset_init", 8'd0, 5'd0, 8'h00);
        #9;
        iReset_n = 1'b1;

        foreach (vecs[i]) begin
            iMop    = vecs[i].mop;
            iFlagZ  = vecs[i].z;
            iStall  = vecs[i].stall;
            iIntReq = vecs[i].irq;
            #1;
            check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].st, vecs[i].omop);
            @(posedge iClock);
            #2;
        end

        // Mid-flow asynchronous reset at uPC=50 while a strobe is active.
        iMop    = 8'hFF;
        iStall  = 1'b0;
        iIntReq = 1'b0;
        repeat (3) @(posedge iClock);
        #2;
        check("pre_reset_exec50", 8'd50, V|PI, 8'h01);
        iReset_n = 1'b0;
        #1;
        check("reset_async", 8'd0, 5'd0, 8'h00);
        @(posedge iClock);
        #2;
        check("reset_hold", 8'd0, 5'd0, 8'h00);
        iMop     = 8'h5A;
        iReset_n = 1'b1;
        #1;
        check("reset_release", 8'd0, 5'd0, 8'h00);
        @(posedge iClock);
        #2;
        check("first_edge_fetch", 8'd0, 5'd0, 8'h5A);
        iMop = 8'hFF;
        @(posedge iClock);
        #2;
        check("post_reset_exec", 8'd0, V|EF, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dzcpu_useq.md
DZCPU_USEQ -- requirements
Module: dzcpu_useq

Interface
REQ-001 iClock  in  1  sole clock; all state changes on the rising edge.
REQ-002 iReset_n  in  1  asynchronous, active-low reset.
REQ-003 iMop  in  8  memory read data: opcode byte at current PC.
REQ-004 iFlowIdx  in  8  flow start index from the main opcode LUT, indexed by oMop.
REQ-005 iCbFlowIdx  in  8  flow start index from the CB-prefix LUT, indexed by oMop.
REQ-006 iUop  in  13  micro-op word from the ucode ROM at oUopAddr (combinational, same cycle).
REQ-007 iFlagZ  in  1  current Z flag from the datapath.
REQ-008 iStall  in  1  memory wait; freezes the sequencer.
REQ-009 iIntReq  in  1  pending, enabled interrupt request.
REQ-010 oMop  out  8  latched opcode (main or CB), driven to both LUTs.
REQ-011 oUopAddr  out  8  ucode ROM address (micro-PC).
REQ-012 oUopValid  out  1  datapath executes oUopBody this cycle.
REQ-013 oUopBody  out  9  iUop[8:0], passed through unmodified.
REQ-014 oPcInc  out  1  one-cycle PC increment strobe.
REQ-015 oUpdateFlags  out  1  datapath commits flags from this micro-op.
REQ-016 oEof  out  1  last micro-op of the instruction.
REQ-017 oIntAck  out  1  one-cycle interrupt-accept pulse.

Function
REQ-018 iUop[12:9] is the flow field: OP=0, INC=1, EOF=2, INC_EOF=3, EOF_FU=4, INC_EOF_FU=5, UPDATE_FLAGS=6, INC_EOF_Z=7, INC_EOF_NZ=8, NOP=9; codes 10-15 behave as OP.
REQ-019 iUop[8:4] == 5'h1F (JCB) shall redirect to CB dispatch regardless of the flow field's eof meaning; the INC part of the flow field still applies.
REQ-020 States: FETCH, DISPATCH, EXEC, CB_FETCH, CB_DISPATCH.
REQ-021 FETCH: latch iMop into oMop; go to DISPATCH. DISPATCH: set uPC to iFlowIdx; go to EXEC.
REQ-022 CB_FETCH: latch iMop into oMop; go to CB_DISPATCH. CB_DISPATCH: set uPC to iCbFlowIdx; go to EXEC.
REQ-023 oUopValid=1 only in EXEC when iStall=0; oUopAddr=uPC in every state.
REQ-024 EXEC, per flow code:
- INC and INC_* codes assert oPcInc.
- *_FU and UPDATE_FLAGS assert oUpdateFlags.
- OP, INC, UPDATE_FLAGS and NOP advance uPC by 1.
- EOF codes assert oEof and end the instruction.
REQ-025 INC_EOF_Z ends the instruction if iFlagZ=1, else advances uPC; INC_EOF_NZ ends it if iFlagZ=0, else advances. oEof follows the taken decision.
REQ-026 Instruction end: next state FETCH; if iIntReq=1 in that cycle, next state is EXEC with uPC=8'd238 (INT_FLOW_IDX) and oIntAck pulses.
REQ-027 The uPC increment is 8-bit and wraps 255 -> 0 with no error indication.
REQ-028 iStall=1: no state, uPC or oMop change; oPcInc, oUpdateFlags, oEof, oIntAck and oUopValid held 0; outputs resume the cycle iStall falls.
REQ-029 Latency: a one-uop instruction takes 3 cycles (FETCH, DISPATCH, EXEC); a CB instruction adds 2 cycles after its JCB micro-op.
REQ-030 oPcInc, oUpdateFlags, oEof and oIntAck are combinational decodes of the current EXEC micro-op and are 0 outside EXEC.

Reset
REQ-031 Asserting iReset_n low forces: state FETCH, uPC=0, oMop=0, and all strobes to 0, immediately and asynchronously.
REQ-032 Reset mid-instruction abandons the flow; no partial strobe is emitted after release.
REQ-033 The first rising edge after deassertion is a FETCH edge.

Structure
REQ-034 Flow codes, the JCB op code, INT_FLOW_IDX and the state encodings belong in the shared z80 definitions package/header.
REQ-035 One sub-module, dzcpu_useq_flowdec: combinational decode of iUop[12:4] plus iFlagZ into inc, update_flags, eof_taken and jcb.
REQ-036 The LUTs and ROM are instantiated by the parent, not inside this block.

Verification
REQ-037 Reset: hold iReset_n=0 mid-EXEC at uPC=50 -> oUopAddr=0 and all strobes 0 immediately; FETCH on the first edge after release.
REQ-038 NOP: iMop=0x00, iFlowIdx=162, ROM[162]=INC_EOF -> EXEC in cycle 3 with oUopAddr=162, oPcInc=1, oEof=1; FETCH next.
REQ-039 JRNZ: flow 17 with ROM[19]=INC_EOF_Z. With Z=1 -> oEof at uPC=19. With Z=0 -> uPC steps 20, 21, 22 and oEof is asserted at 22.
REQ-040 CB: iMop=0xCB, flow 13, JCB at uPC=15 -> CB_FETCH latches 0x7C; iCbFlowIdx=16 -> EXEC at 16 with oUpdateFlags=1 and oEof=1.
REQ-041 Stall: iStall=1 for 3 cycles at uPC=50 -> oUopAddr holds 50, oUopValid=0, no oPcInc; execution resumes at 50.
REQ-042 Interrupt: iIntReq=1 at an EOF micro-op -> one-cycle oIntAck, next oUopAddr=238, state EXEC, and no FETCH in between.
